// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the MIPS R2000 five-stage pipeline.
// Drives a request/acknowledge data-memory bus, stalls upstream while a
// transfer is outstanding, and registers the MEM/WB bundle.
// Optional feature macro: MEM_TIMEOUT_EN (bus-timeout abandon + sticky mem_err).
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    input  logic [31:0] res,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register,
    input  logic        zero,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        branch_taken,
    output logic [1:0]  wb_WB,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb,
    output logic [4:0]  write_register_wb,
    output logic        mem_err
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t state, state_nxt;
    logic   access;
    logic   is_load;
    logic   load_done;
    logic   timeout;
    logic   abort_q;

    // The counter must be able to hold TIMEOUT_CYCLES-1.
    if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_cfg_check
        $error("mem_stage: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    assign access       = m_MEM[1] | m_MEM[0];
    // With both bits set the access is a store, so it never returns data.
    assign is_load      = m_MEM[1] & ~m_MEM[0];
    assign dmem_we      = m_MEM[0];
    assign dmem_addr    = {res[31:2], 2'b00};
    assign dmem_wdata   = write_data_ex;
    assign branch_taken = m_MEM[2] & zero;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             mem_err_q;

    // Abandon decision: last WAIT cycle allowed without an ack.
    assign timeout = (state == WAIT) && !dmem_ack &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter, one-cycle abort release and sticky error flag.
    // The timed-out instruction is still held upstream during the abort
    // cycle; with the request dropped it retires with read data 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            abort_q   <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            abort_q <= timeout;
            if (timeout)
                mem_err_q <= 1'b1;
            if (state == WAIT && !dmem_ack && !timeout)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign timeout = 1'b0;
    assign abort_q = 1'b0;
    assign mem_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state: enter WAIT on an un-acked request, leave on ack or abandon.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_stall) state_nxt = WAIT;
            WAIT:    if (dmem_ack || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: bus request, stall and load-completion strobe.
    always_comb begin
        dmem_req = 1'b0;
        if (!rst && !abort_q)
            dmem_req = (state == WAIT) || access;
        mem_stall = dmem_req & ~dmem_ack;
        load_done = dmem_req & dmem_ack & is_load;
    end

    // MEM/WB register: bubble the WB controls while stalled, capture otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_WB             <= 2'b00;
            read_data_wb      <= 32'd0;
            alu_res_wb        <= 32'd0;
            write_register_wb <= 5'd0;
        end else if (mem_stall) begin
            wb_WB <= 2'b00;
        end else begin
            wb_WB             <= wb_MEM;
            alu_res_wb        <= res;
            write_register_wb <= write_register;
            read_data_wb      <= load_done ? dmem_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, hand-written corner sequences and a randomized
// transaction-level model for mem_stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_MEM;
    logic [1:0]  wb_MEM;
    logic [31:0] res, write_data_ex, dmem_rdata;
    logic [4:0]  write_register;
    logic        zero, dmem_ack;
    logic        dmem_req, dmem_we, mem_stall, branch_taken, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, read_data_wb, alu_res_wb;
    logic [1:0]  wb_WB;
    logic [4:0]  write_register_wb;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .m_MEM(m_MEM), .wb_MEM(wb_MEM), .res(res),
        .write_data_ex(write_data_ex), .write_register(write_register), .zero(zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .branch_taken(branch_taken), .wb_WB(wb_WB),
        .read_data_wb(read_data_wb), .alu_res_wb(alu_res_wb),
        .write_register_wb(write_register_wb), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] res;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        zero;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic        e_bt;
        logic [31:0] e_addr;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] r,
                         input logic [31:0] wd, input logic [4:0] wr, input logic z);
        m_MEM = m; wb_MEM = wb; res = r; write_data_ex = wd; write_register = wr; zero = z;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] l_res, l_rd;
        logic [4:0]  l_wreg;
        logic        acc, stall_exp;
        int          dly, stalls, completions;

        vt[0] = '{3'b010, 2'b11, 32'h0000_0104, 32'h0,         5'd3,  1'b0, 1'b1, 32'hCAFE_F00D,
                  1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'hCAFE_F00D};
        vt[1] = '{3'b001, 2'b00, 32'h0000_0203, 32'h1234_5678, 5'd0,  1'b0, 1'b1, 32'h1111_1111,
                  1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0};
        vt[2] = '{3'b100, 2'b01, 32'h0000_0007, 32'h0,         5'd9,  1'b1, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0};
        vt[3] = '{3'b100, 2'b01, 32'h0000_0008, 32'h0,         5'd2,  1'b0, 1'b1, 32'hDEAD_BEEF,
                  1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0};
        vt[4] = '{3'b011, 2'b11, 32'h1000_0006, 32'hA0A0_0505, 5'd4,  1'b0, 1'b1, 32'h5555_5555,
                  1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0};
        vt[5] = '{3'b010, 2'b10, 32'hFFFF_FFFF, 32'h0,         5'd31, 1'b0, 1'b1, 32'h0000_0001,
                  1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0001};
        vt[6] = '{3'b110, 2'b11, 32'h0000_0020, 32'h0,         5'd6,  1'b1, 1'b1, 32'hA5A5_A5A5,
                  1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5};
        vt[7] = '{3'b000, 2'b01, 32'h0000_ABCD, 32'h0,         5'd5,  1'b0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 32'h0000_ABCC, 32'h0};

        // Reset state
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        apply(3'b010, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        #2;
        chk("reset dmem_req", dmem_req, 0);
        chk("reset mem_stall", mem_stall, 0);
        next_cycle();
        chk("reset wb_WB", wb_WB, 0);
        chk("reset read_data_wb", read_data_wb, 0);
        chk("reset alu_res_wb", alu_res_wb, 0);
        chk("reset write_register_wb", write_register_wb, 0);
        chk("reset mem_err", mem_err, 0);
        apply(3'b000, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        rst = 1'b0;
        next_cycle();

        // Vector table, applied back to back (consecutive requests, no idle cycle)
        for (int i = 0; i < 8; i++) begin
            apply(vt[i].m, vt[i].wb, vt[i].res, vt[i].wdata, vt[i].wreg, vt[i].zero);
            dmem_ack = vt[i].ack; dmem_rdata = vt[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d dmem_req", i), dmem_req, vt[i].e_req);
            chk($sformatf("vec%0d mem_stall", i), mem_stall, 0);
            chk($sformatf("vec%0d branch_taken", i), branch_taken, vt[i].e_bt);
            chk($sformatf("vec%0d dmem_addr", i), dmem_addr, vt[i].e_addr);
            if (vt[i].e_req) begin
                chk($sformatf("vec%0d dmem_we", i), dmem_we, vt[i].e_we);
                chk($sformatf("vec%0d dmem_wdata", i), dmem_wdata, vt[i].wdata);
            end
            next_cycle();
            chk($sformatf("vec%0d wb_WB", i), wb_WB, vt[i].wb);
            chk($sformatf("vec%0d alu_res_wb", i), alu_res_wb, vt[i].res);
            chk($sformatf("vec%0d write_register_wb", i), write_register_wb, vt[i].wreg);
            chk($sformatf("vec%0d read_data_wb", i), read_data_wb, vt[i].e_rd);
        end

        // 3-wait store: ack on the 4th cycle
        apply(3'b001, 2'b01, 32'h0000_0203, 32'h1234_5678, 5'd7, 1'b0);
        stalls = 0; completions = 0;
        for (int k = 0; k < 4; k++) begin
            dmem_ack = (k == 3); dmem_rdata = $urandom;
            @(negedge clk);
            if (mem_stall) stalls++;
            chk("store3 mem_stall", mem_stall, (k < 3));
            chk("store3 dmem_req", dmem_req, 1);
            chk("store3 dmem_we", dmem_we, 1);
            chk("store3 dmem_addr", dmem_addr, 32'h0000_0200);
            chk("store3 dmem_wdata", dmem_wdata, 32'h1234_5678);
            next_cycle();
            if (wb_WB != 2'b00) completions++;
            chk("store3 wb_WB", wb_WB, (k < 3) ? 2'b00 : 2'b01);
        end
        chk("store3 stall cycles", stalls, 3);
        chk("store3 completions", completions, 1);
        chk("store3 read_data_wb", read_data_wb, 0);
        chk("store3 alu_res_wb", alu_res_wb, 32'h0000_0203);
        chk("store3 write_register_wb", write_register_wb, 7);

        // Randomized instruction stream against a transaction-level model
        l_res = alu_res_wb; l_rd = 32'h0; l_wreg = 5'd7;
        for (int n = 0; n < 200; n++) begin
            apply(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            acc = (m_MEM[1] || m_MEM[0]);
            dly = acc ? int'($urandom_range(0, 3)) : 0;
            for (int k = 0; k <= dly; k++) begin
                dmem_rdata = $urandom;
                dmem_ack   = acc ? (k == dly) : 1'($urandom_range(0, 1));
                stall_exp  = acc && (k < dly);
                @(negedge clk);
                chk("rand dmem_req", dmem_req, acc);
                chk("rand mem_stall", mem_stall, stall_exp);
                chk("rand dmem_addr", dmem_addr, res & ~32'h3);
                chk("rand dmem_we", dmem_we, m_MEM == 3'b001 || m_MEM == 3'b011 ||
                                             m_MEM == 3'b101 || m_MEM == 3'b111);
                chk("rand branch_taken", branch_taken, (m_MEM >= 3'd4) && zero);
                if (!stall_exp) begin
                    l_res  = res;
                    l_wreg = write_register;
                    l_rd   = (m_MEM == 3'b010 || m_MEM == 3'b110) ? dmem_rdata : 32'h0;
                end
                next_cycle();
                chk("rand wb_WB", wb_WB, stall_exp ? 2'b00 : wb_MEM);
                chk("rand alu_res_wb", alu_res_wb, l_res);
                chk("rand write_register_wb", write_register_wb, l_wreg);
                chk("rand read_data_wb", read_data_wb, l_rd);
            end
        end

        // Asynchronous reset in the middle of WAIT
        apply(3'b010, 2'b11, 32'h0000_0300, 32'h0, 5'd12, 1'b0);
        dmem_ack = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("midwait mem_stall", mem_stall, 1);
        #1 rst = 1'b1;
        #1;
        chk("midwait rst dmem_req", dmem_req, 0);
        chk("midwait rst mem_stall", mem_stall, 0);
        chk("midwait rst wb_WB", wb_WB, 0);
        chk("midwait rst read_data_wb", read_data_wb, 0);
        chk("midwait rst alu_res_wb", alu_res_wb, 0);
        chk("midwait rst write_register_wb", write_register_wb, 0);
        chk("midwait rst mem_err", mem_err, 0);
        next_cycle();
        apply(3'b000, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("after reset no retry dmem_req", dmem_req, 0);
        chk("after reset mem_stall", mem_stall, 0);
        next_cycle();

`ifdef MEM_TIMEOUT_EN
        // Load never acked: 5 stalled cycles, then released with read data 0
        apply(3'b010, 2'b11, 32'h0000_0040, 32'h0, 5'd4, 1'b0);
        dmem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("timeout mem_stall", mem_stall, 1);
            chk("timeout dmem_req", dmem_req, 1);
            next_cycle();
            chk("timeout bubble wb_WB", wb_WB, 0);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("timeout release mem_stall", mem_stall, 0);
        chk("timeout release dmem_req", dmem_req, 0);
        next_cycle();
        chk("timeout wb_WB", wb_WB, 2'b11);
        chk("timeout read_data_wb", read_data_wb, 0);
        chk("timeout alu_res_wb", alu_res_wb, 32'h0000_0040);
        chk("timeout mem_err", mem_err, 1);
        apply(3'b000, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_ack = 1'b0;
        for (int k = 0; k < 3; k++) next_cycle();
        chk("timeout mem_err sticky", mem_err, 1);
        #1 rst = 1'b1;
        #1 chk("timeout mem_err cleared", mem_err, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
`else
        // Without the timeout the FSM waits indefinitely and mem_err stays 0
        apply(3'b010, 2'b01, 32'h0000_0050, 32'h0, 5'd8, 1'b0);
        dmem_ack = 1'b0;
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            next_cycle();
        end
        chk("no-timeout stall cycles", stalls, 20);
        chk("no-timeout mem_err", mem_err, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        next_cycle();
        chk("no-timeout late load read_data_wb", read_data_wb, 32'h0BAD_F00D);
        chk("no-timeout late load wb_WB", wb_WB, 2'b01);
        dmem_ack = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the MIPS R2000 five-stage pipeline, directly downstream of EX.
- Consumes the EX/MEM register outputs: m_MEM, wb_MEM, res, write_data_ex, write_register, zero.
- Performs load/store over a request/acknowledge data-memory bus and stalls the pipeline while a transfer is outstanding.
- Produces the registered MEM/WB bundle for write-back and the forwarding unit, plus the branch-taken decision.

Parameters:
- TIMEOUT_CYCLES, 16, number of WAIT cycles without dmem_ack before a transfer is abandoned (used only with the optional feature).
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- m_MEM  in  3  MEM control: [2]=branch, [1]=mem_read, [0]=mem_write.
- wb_MEM  in  2  WB control: [1]=mem_to_reg, [0]=reg_write.
- res  in  32  ALU result from EX, used as the byte address.
- write_data_ex  in  32  store data.
- write_register  in  5  destination register.
- zero  in  1  ALU zero flag.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid only in a cycle where dmem_ack=1.
- dmem_ack  in  1  transfer completes this cycle.
- mem_stall  out  1  freeze IF/ID/EX and the EX/MEM register.
- branch_taken  out  1  PCSrc.
- wb_WB  out  2  registered WB control.
- read_data_wb  out  32  registered load data.
- alu_res_wb  out  32  registered res.
- write_register_wb  out  5  registered destination.
- mem_err  out  1  sticky bus-timeout flag; tied to 0 without the optional feature.

Behaviour:
- Definitions:
  - access = m_MEM[1] | m_MEM[0].
  - dmem_we = m_MEM[0]. If both bits are set, the transfer is treated as a store and read_data_wb captures 0.
  - dmem_addr = {res[31:2],2'b00}; res[1:0] is ignored.
  - dmem_wdata = write_data_ex.
  - branch_taken = m_MEM[2] & zero (combinational; not gated by stall).
- FSM states: IDLE, WAIT.
  - IDLE: dmem_req = access. If access and dmem_ack: complete in the same cycle (zero-wait). If access and no ack: go to WAIT, cnt <= 0.
  - WAIT: dmem_req = 1, held with address, data and we stable. On dmem_ack: complete, go to IDLE. Otherwise cnt <= cnt+1.
- mem_stall = dmem_req & ~dmem_ack. Upstream holds the EX/MEM inputs constant while mem_stall=1.
- MEM/WB register, updated on every rising clk:
  - Stall cycle: wb_WB <= 2'b00 (bubble). Other fields hold their previous values. No duplicate write-back is possible.
  - Otherwise: wb_WB <= wb_MEM, alu_res_wb <= res, write_register_wb <= write_register.
  - read_data_wb <= dmem_rdata on a completing load; 0 on stores and non-memory instructions.
  - A non-access instruction passes through with 1-cycle latency and no stall.
  - Load latency is 1 cycle after the dmem_ack cycle.
- Back-to-back accesses: after completion the FSM is in IDLE and the next instruction may request in the following cycle. No idle cycle is inserted.
- Reset (asynchronous, any time, including mid-WAIT):
  - state=IDLE, cnt=0, wb_WB=0, read_data_wb=0, alu_res_wb=0, write_register_wb=0, mem_err=0.
  - dmem_req is forced to 0 while rst=1.
  - An abandoned transfer is not retried after reset.
- dmem_ack while dmem_req=0 is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - In WAIT, when cnt reaches TIMEOUT_CYCLES-1 with no ack, the transfer is abandoned that cycle.
  - mem_stall deasserts and dmem_req drops at the next edge.
  - The MEM/WB register captures normally, with read_data_wb=0.
  - mem_err is set sticky until reset. FSM returns to IDLE.
- Undefined: no counter is compiled, the FSM waits indefinitely in WAIT, and mem_err is constant 0.

Test Plan:
- Reset: assert rst mid-WAIT -> dmem_req=0, mem_stall=0, all WB outputs 0 immediately (asynchronous).
- Zero-wait load:
  - Stimulus: m_MEM=3'b010, res=0x0000_0104, dmem_ack=1 in the same cycle, dmem_rdata=0xCAFE_F00D.
  - Response: dmem_addr=0x104, no stall; next cycle read_data_wb=0xCAFEF00D, wb_WB=wb_MEM.
- 3-wait store:
  - Stimulus: m_MEM=3'b001, res=0x0000_0203, write_data_ex=0x1234_5678, ack on the 4th cycle.
  - Response: dmem_addr=0x200, dmem_we=1, mem_stall=1 for 3 cycles, wb_WB=0 during the stall, one completion.
- Branch plus passthrough:
  - Stimulus: m_MEM=3'b100, zero=1, wb_MEM=2'b01, res=7, write_register=9.
  - Response: branch_taken=1, dmem_req=0, next cycle alu_res_wb=7, write_register_wb=9.
- Back-to-back:
  - Stimulus: load then store in consecutive instructions, each acked in its first cycle.
  - Response: two requests on consecutive cycles, no stall.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4:
  - Stimulus: load with no ack.
  - Response: mem_stall=1 for 5 cycles (IDLE + 4 WAIT), then released, read_data_wb=0, mem_err=1 held until rst.
